// File: rtl/sys_call_unit.sv
// rtl/sys_call_unit.sv - syscall service unit: console record FIFO, string walker, counted exit
module sys_call_unit #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int EXIT_DELAY = 500,
  parameter int MAX_STR    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sc_valid,
  output logic              sc_ready,
  input  logic [DATA_W-1:0] sc_code,
  input  logic [DATA_W-1:0] sc_arg,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              con_valid,
  input  logic              con_ready,
  output logic [1:0]        con_type,
  output logic [DATA_W-1:0] con_data,
  output logic              busy,
  output logic              halt,
  output logic              err_code
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCNT_W = $clog2(MAX_STR + 1);
  localparam int ECNT_W = $clog2(EXIT_DELAY + 1);
  localparam logic [1:0] T_INT  = 2'd0;
  localparam logic [1:0] T_CHAR = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_STR_RD, S_STR_WAIT, S_DRAIN, S_EXIT_CNT, S_HALTED
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_addr;
  logic [SCNT_W-1:0]   r_scnt;
  logic [ECNT_W-1:0]   r_ecnt;
  logic                r_halt;
  logic                r_err;

  logic [1:0]          r_fifo_type [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  logic [1:0]          w_push_type;
  logic [DATA_W-1:0]   w_push_data;
  logic                w_str_end;

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && con_ready;
  assign w_str_end = (mem_rdata == 8'h00) || (r_scnt == SCNT_W'(MAX_STR));

  // sc_ready is forced low while reset is held so the upstream never sees a handshake in reset
  assign sc_ready  = rst_n && (r_state == S_IDLE) && !w_full;
  assign w_accept  = sc_valid && sc_ready;
  assign mem_rd_en = (r_state == S_STR_RD) && !w_full;
  assign mem_addr  = r_addr;
  assign con_valid = !w_empty;
  assign con_type  = w_empty ? 2'd0 : r_fifo_type[r_rd_ptr];
  assign con_data  = w_empty ? '0 : r_fifo_data[r_rd_ptr];
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign halt      = r_halt;
  assign err_code  = r_err;

  always_comb begin
    w_push      = 1'b0;
    w_push_type = T_INT;
    w_push_data = '0;
    if (r_state == S_IDLE && w_accept) begin
      if (sc_code == DATA_W'(1)) begin
        w_push      = 1'b1;
        w_push_type = T_INT;
        w_push_data = sc_arg;
      end else if (sc_code == DATA_W'(11)) begin
        w_push      = 1'b1;
        w_push_type = T_CHAR;
        w_push_data = {{(DATA_W-8){1'b0}}, sc_arg[7:0]};
      end
    end else if (r_state == S_STR_WAIT && !w_str_end) begin
      w_push      = 1'b1;
      w_push_type = T_CHAR;
      w_push_data = {{(DATA_W-8){1'b0}}, mem_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && (!w_full || w_pop)) begin
      r_fifo_type[r_wr_ptr] <= w_push_type;
      r_fifo_data[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push && (!w_full || w_pop)) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push && (!w_full || w_pop), w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_scnt  <= '0;
      r_ecnt  <= '0;
      r_halt  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (sc_code == DATA_W'(4)) begin
              r_addr  <= sc_arg;
              r_scnt  <= '0;
              r_state <= S_STR_RD;
            end else if (sc_code == DATA_W'(10)) begin
              r_state <= S_DRAIN;
            end else if (sc_code != DATA_W'(1) && sc_code != DATA_W'(11)) begin
              r_err <= 1'b1;
            end
          end
        end
        S_STR_RD: begin
          if (!w_full) r_state <= S_STR_WAIT;
        end
        S_STR_WAIT: begin
          if (w_str_end) begin
            r_state <= S_IDLE;
          end else begin
            r_addr  <= r_addr + DATA_W'(1);
            r_scnt  <= r_scnt + SCNT_W'(1);
            r_state <= S_STR_RD;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_ecnt  <= ECNT_W'(EXIT_DELAY);
            r_state <= S_EXIT_CNT;
          end
        end
        S_EXIT_CNT: begin
          // the edge that sees the count at 1 is the EXIT_DELAY-th edge after DRAIN
          if (r_ecnt == ECNT_W'(1)) begin
            r_halt  <= 1'b1;
            r_state <= S_HALTED;
          end else begin
            r_ecnt <= r_ecnt - ECNT_W'(1);
          end
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_call_unit.sv
// tb/tb_sys_call_unit.sv - directed self-checking bench for sys_call_unit
module tb_sys_call_unit;

  localparam int EXIT_D = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sc_valid;
  logic        sc_ready;
  logic [31:0] sc_code;
  logic [31:0] sc_arg;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        con_valid;
  logic        con_ready;
  logic [1:0]  con_type;
  logic [31:0] con_data;
  logic        busy;
  logic        halt;
  logic        err_code;

  sys_call_unit #(
    .DATA_W(32), .FIFO_DEPTH(8), .EXIT_DELAY(EXIT_D), .MAX_STR(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_code(sc_code), .sc_arg(sc_arg),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .con_valid(con_valid), .con_ready(con_ready), .con_type(con_type), .con_data(con_data),
    .busy(busy), .halt(halt), .err_code(err_code)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:1023];
  logic [33:0] cap [$];
  logic [31:0] reads [$];
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr[9:0]];
      reads.push_back(mem_addr);
    end
    if (con_valid && con_ready) cap.push_back({con_type, con_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] code, input logic [31:0] arg);
    bit ok;
    ok = 1'b0;
    sc_code  = code;
    sc_arg   = arg;
    sc_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (sc_ready) ok = 1'b1;
      @(negedge clk);
    end
    sc_valid = 1'b0;
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int bound, input bit rand_ready);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (rand_ready) con_ready = 1'($urandom_range(0, 1));
      if (!busy) done = 1'b1;
    end
    con_ready = 1'b1;
    if (!done) check("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int pat [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    int last_pop;
    int halt_at;
    int pops;
    int ncap;

    rst_n = 1'b0; sc_valid = 1'b0; sc_code = '0; sc_arg = '0; con_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = "H";
    mem[10'h101] = "i";
    mem[10'h102] = 8'h00;
    for (int i = 0; i < 80; i++) mem[10'h200 + i] = 8'(8'h21 + i);

    repeat (2) @(negedge clk);
    check("rst_ctrl", {sc_ready, mem_rd_en, con_valid, busy, halt, err_code}, 6'b0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_con", {con_type, con_data}, 34'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", sc_ready, 1'b1);

    // print int
    issue(32'd1, 32'd42);
    check("int_valid", con_valid, 1'b1);
    check("int_rec", {con_type, con_data}, {2'd0, 32'd42});
    @(negedge clk);
    check("int_drained", {con_valid, busy}, 2'b00);
    cap.delete();

    // full back-pressure
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(32'd11, 32'h100 + 32'(8'h41 + i));
    check("full_ready_low", sc_ready, 1'b0);
    check("full_head", {con_valid, con_type, con_data}, {1'b1, 2'd1, 32'h41});
    con_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("bp_count", cap.size(), 8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      check("bp_rec", cap[i], {2'd1, 32'(8'h41 + i)});
    cap.delete(); reads.delete();

    // string walk "Hi"
    issue(32'd4, 32'h100);
    wait_idle(100, 1'b0);
    check("hi_count", cap.size(), 2);
    if (cap.size() == 2) begin
      check("hi_0", cap[0], {2'd1, 32'h48});
      check("hi_1", cap[1], {2'd1, 32'h69});
    end
    check("hi_reads", reads.size(), 3);
    for (int i = 0; i < 3 && i < reads.size(); i++) check("hi_addr", reads[i], 32'h100 + 32'(i));
    check("hi_ready", sc_ready, 1'b1);
    cap.delete(); reads.delete();

    // unterminated string under random console stalls
    issue(32'd4, 32'h200);
    wait_idle(3000, 1'b1);
    check("long_count", cap.size(), 64);
    for (int i = 0; i < 64 && i < cap.size(); i++) check("long_rec", cap[i], {2'd1, 32'(8'h21 + i)});
    check("long_reads", reads.size(), 65);
    cap.delete(); reads.delete();

    // unknown code
    issue(32'd7, 32'd5);
    check("err_pulse", err_code, 1'b1);
    @(negedge clk);
    check("err_clear", err_code, 1'b0);
    check("err_norec", {con_valid, 32'(cap.size())}, 33'd0);

    // exit with drain
    con_ready = 1'b0;
    issue(32'd11, 32'h78);
    issue(32'd11, 32'h79);
    issue(32'd11, 32'h7a);
    issue(32'd10, 32'd0);
    check("drain_stall", {sc_ready, busy, halt}, 3'b010);
    last_pop = -1; halt_at = -1; pops = 0;
    for (int n = 0; n < 300 && halt_at < 0; n++) begin
      if (n > 0) @(negedge clk);
      con_ready = (n < 8) ? 1'(pat[n]) : 1'b1;
      if (halt) halt_at = n;
      else if (con_valid && con_ready) begin
        last_pop = n;
        pops++;
      end
    end
    check("exit_pops", pops, 3);
    check("exit_order", {cap[0], cap[1], cap[2]}, {2'd1, 32'h78, 2'd1, 32'h79, 2'd1, 32'h7a});
    // one DRAIN cycle sees the empty FIFO, then EXIT_D counted cycles
    check("exit_delay", halt_at - last_pop, EXIT_D + 2);
    ncap = cap.size();
    sc_code = 32'd1; sc_arg = 32'd5; sc_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("halted_ready", sc_ready, 1'b0);
    end
    sc_valid = 1'b0;
    check("halted_state", {halt, con_valid, 32'(cap.size())}, {1'b1, 1'b0, 32'(ncap)});

    // async reset mid-string
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    con_ready = 1'b0;
    issue(32'd4, 32'h200);
    repeat (6) @(negedge clk);
    check("mid_pre", {con_valid, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {sc_ready, mem_rd_en, con_valid, busy, halt, err_code}, 6'b0);
    check("mid_rst_data", {mem_addr, con_type, con_data}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_after", {con_valid, busy, sc_ready, halt}, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
